// File: rtl/fifo_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_seq_ctrl
//
// Sequences one fill/drain pass over a bank of DIM delay FIFOs, each DIM
// entries deep and BITS wide.
//
// FILL:  DIM data beats are shifted into every FIFO at the same time.
// DRAIN: a diagonal enable wavefront of 2*DIM-1 steps runs across the bank.
//        Lane i shifts during steps i .. i+DIM-1.
// DONE:  a one-cycle completion pulse.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous, active-low reset
//   i_start      begin a pass (only looked at in IDLE)
//   i_abort      synchronous cancel of the current pass
//   i_in_valid   requester presents a fill beat on i_in_data
//   i_in_data    one beat; lane i is bits [i*BITS +: BITS]
//   o_in_ready   controller accepts a beat this cycle (FILL only)
//   o_fifo_en    registered per-FIFO shift enable
//   o_fifo_d     registered per-FIFO shift-in data
//   o_out_valid  lane i FIFO output carries drained data
//   o_busy       high whenever the controller is not IDLE
//   o_done       single-cycle pass-complete pulse
// ---------------------------------------------------------------------------
module fifo_seq_ctrl #(
   parameter int DIM  = 8,
   parameter int BITS = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_start,
   input  logic                i_abort,
   input  logic                i_in_valid,
   input  logic [DIM*BITS-1:0] i_in_data,
   output logic                o_in_ready,
   output logic [DIM-1:0]      o_fifo_en,
   output logic [DIM*BITS-1:0] o_fifo_d,
   output logic [DIM-1:0]      o_out_valid,
   output logic                o_busy,
   output logic                o_done
);

   localparam int FILL_W = $clog2(DIM + 1);
   localparam int STEP_W = $clog2(2 * DIM);

   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DIM - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(2 * DIM - 2);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DRAIN,
      DONE
   } state_t;

   state_t              r_state;
   logic [FILL_W-1:0]   r_fillCnt;
   logic [STEP_W-1:0]   r_step;
   logic [DIM-1:0]      r_fifoEn;
   logic [DIM*BITS-1:0] r_fifoD;
   logic [DIM-1:0]      r_outValid;
   logic                r_drainEn;

   logic                w_beat;
   logic [DIM-1:0]      w_drainMask;

   // A beat is taken only in FILL. Abort wins over the beat, so a beat
   // offered in the same cycle as an abort is never counted.
   assign w_beat = (r_state == FILL) && i_in_valid && !i_abort;

   // The diagonal drain wavefront for the current step.
   // Lane i is enabled while the step lies in the window [i, i+DIM).
   always_comb begin
      w_drainMask = '0;
      for (int i = 0; i < DIM; i++) begin
         w_drainMask[i] = (int'(r_step) >= i) && (int'(r_step) < i + DIM);
      end
   end

   // Main sequencer. All outputs are registered here.
   //
   // The enable and data outputs fall back to zero every cycle unless a
   // state explicitly drives them.
   //
   // r_drainEn marks enables that came from the drain wavefront. Only those
   // enables show up on o_out_valid one cycle later; fill enables never do.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_fillCnt  <= '0;
         r_step     <= '0;
         r_fifoEn   <= '0;
         r_fifoD    <= '0;
         r_outValid <= '0;
         r_drainEn  <= 1'b0;
      end else begin
         r_outValid <= r_drainEn ? r_fifoEn : '0;
         r_fifoEn   <= '0;
         r_fifoD    <= '0;
         r_drainEn  <= 1'b0;

         if (i_abort && (r_state != IDLE)) begin
            r_state    <= IDLE;
            r_fillCnt  <= '0;
            r_step     <= '0;
            r_outValid <= '0;
         end else begin
            unique case (r_state)
               IDLE: begin
                  if (i_start && !i_abort) begin
                     r_state <= FILL;
                  end
               end
               FILL: begin
                  if (w_beat) begin
                     r_fifoEn <= '1;
                     r_fifoD  <= i_in_data;
                     if (r_fillCnt == FILL_LAST) begin
                        r_fillCnt <= '0;
                        r_step    <= '0;
                        r_state   <= DRAIN;
                     end else begin
                        r_fillCnt <= r_fillCnt + 1'b1;
                     end
                  end
               end
               DRAIN: begin
                  r_fifoEn  <= w_drainMask;
                  r_drainEn <= 1'b1;
                  if (r_step == STEP_LAST) begin
                     r_step  <= '0;
                     r_state <= DONE;
                  end else begin
                     r_step <= r_step + 1'b1;
                  end
               end
               DONE: begin
                  r_state <= IDLE;
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign o_in_ready  = (r_state == FILL);
   assign o_busy      = (r_state != IDLE);
   assign o_done      = (r_state == DONE);
   assign o_fifo_en   = r_fifoEn;
   assign o_fifo_d    = r_fifoD;
   assign o_out_valid = r_outValid;

endmodule

// File: tb/tb_fifo_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_seq_ctrl
//
// Directed, table-driven bench for fifo_seq_ctrl.
//
// The main instance uses DIM=4, BITS=8. A second instance uses DIM=1 and
// covers the smallest legal configuration.
//
// Each table row is applied at a falling edge. The outputs are then checked
// 1 time unit after the following rising edge, so every row's expected
// values describe the registered result of that row's cycle.
// ---------------------------------------------------------------------------
module tb_fifo_seq_ctrl;

   localparam int DIM  = 4;
   localparam int BITS = 8;
   localparam int W    = DIM * BITS;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic           abort;
   logic           inValid;
   logic [W-1:0]   inData;
   logic           inReady;
   logic [DIM-1:0] fifoEn;
   logic [W-1:0]   fifoD;
   logic [DIM-1:0] outValid;
   logic           busy;
   logic           done;

   logic           start1;
   logic           abort1;
   logic           inValid1;
   logic [7:0]     inData1;
   logic           inReady1;
   logic [0:0]     fifoEn1;
   logic [7:0]     fifoD1;
   logic [0:0]     outValid1;
   logic           busy1;
   logic           done1;

   int nChecks = 0;
   int nErrors = 0;

   typedef struct {
      string          name;
      logic           start;
      logic           abort;
      logic           inValid;
      logic [W-1:0]   inData;
      logic           expReady;
      logic [DIM-1:0] expEn;
      logic [W-1:0]   expD;
      logic [DIM-1:0] expOv;
      logic           expBusy;
      logic           expDone;
   } vec_t;

   vec_t vecs[$];

   localparam logic [W-1:0] A = 32'h11223344;
   localparam logic [W-1:0] B = 32'h55667788;
   localparam logic [W-1:0] C = 32'h99AABBCC;
   localparam logic [W-1:0] D = 32'hDDEEFF01;
   localparam logic [W-1:0] J = 32'hDEADBEEF;

   fifo_seq_ctrl #(.DIM(DIM), .BITS(BITS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (start),
      .i_abort    (abort),
      .i_in_valid (inValid),
      .i_in_data  (inData),
      .o_in_ready (inReady),
      .o_fifo_en  (fifoEn),
      .o_fifo_d   (fifoD),
      .o_out_valid(outValid),
      .o_busy     (busy),
      .o_done     (done)
   );

   fifo_seq_ctrl #(.DIM(1), .BITS(8)) dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (start1),
      .i_abort    (abort1),
      .i_in_valid (inValid1),
      .i_in_data  (inData1),
      .o_in_ready (inReady1),
      .o_fifo_en  (fifoEn1),
      .o_fifo_d   (fifoD1),
      .o_out_valid(outValid1),
      .o_busy     (busy1),
      .o_done     (done1)
   );

   // 10-unit clock period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle's inputs at the falling edge.
   // Then advance to just past the next rising edge.
   task automatic applyStimulus(input logic s, input logic a, input logic v,
                                input logic [W-1:0] d);
      @(negedge clk);
      start   = s;
      abort   = a;
      inValid = v;
      inData  = d;
      @(posedge clk);
      #1;
   endtask

   // Compare every output of the DIM=4 instance in one comparison.
   task automatic checkOutput(input string name, input logic eReady,
                              input logic [DIM-1:0] eEn, input logic [W-1:0] eD,
                              input logic [DIM-1:0] eOv, input logic eBusy,
                              input logic eDone);
      nChecks++;
      if ({inReady, fifoEn, fifoD, outValid, busy, done} !==
          {eReady, eEn, eD, eOv, eBusy, eDone}) begin
         nErrors++;
         $display("[TB] FAIL %s: got ready=%b en=%b d=%h ov=%b busy=%b done=%b, want ready=%b en=%b d=%h ov=%b busy=%b done=%b",
                  name, inReady, fifoEn, fifoD, outValid, busy, done,
                  eReady, eEn, eD, eOv, eBusy, eDone);
      end
   endtask

   // Compare every output of the DIM=1 instance in one comparison.
   task automatic checkOutput1(input string name, input logic eReady,
                               input logic eEn, input logic [7:0] eD,
                               input logic eOv, input logic eBusy,
                               input logic eDone);
      nChecks++;
      if ({inReady1, fifoEn1, fifoD1, outValid1, busy1, done1} !==
          {eReady, eEn, eD, eOv, eBusy, eDone}) begin
         nErrors++;
         $display("[TB] FAIL %s: got ready=%b en=%b d=%h ov=%b busy=%b done=%b, want ready=%b en=%b d=%h ov=%b busy=%b done=%b",
                  name, inReady1, fifoEn1[0], fifoD1, outValid1[0], busy1, done1,
                  eReady, eEn, eD, eOv, eBusy, eDone);
      end
   endtask

   initial begin
      // Pass 1: back-to-back beats, a stray start during FILL, a full drain.
      //            name         st  ab  v   data  rdy en      d   ov      busy done
      vecs.push_back('{"p1_start",  1, 0, 0, '0, 1, 4'b0000, '0, 4'b0000, 1, 0});
      vecs.push_back('{"p1_beatA",  0, 0, 1, A,  1, 4'b1111, A,  4'b0000, 1, 0});
      vecs.push_back('{"p1_beatB",  1, 0, 1, B,  1, 4'b1111, B,  4'b0000, 1, 0});
      vecs.push_back('{"p1_beatC",  0, 0, 1, C,  1, 4'b1111, C,  4'b0000, 1, 0});
      vecs.push_back('{"p1_beatD",  0, 0, 1, D,  0, 4'b1111, D,  4'b0000, 1, 0});
      vecs.push_back('{"p1_step0",  0, 0, 1, J,  0, 4'b0001, '0, 4'b0000, 1, 0});
      vecs.push_back('{"p1_step1",  0, 0, 0, '0, 0, 4'b0011, '0, 4'b0001, 1, 0});
      vecs.push_back('{"p1_step2",  0, 0, 0, '0, 0, 4'b0111, '0, 4'b0011, 1, 0});
      vecs.push_back('{"p1_step3",  0, 0, 0, '0, 0, 4'b1111, '0, 4'b0111, 1, 0});
      vecs.push_back('{"p1_step4",  0, 0, 0, '0, 0, 4'b1110, '0, 4'b1111, 1, 0});
      vecs.push_back('{"p1_step5",  0, 0, 0, '0, 0, 4'b1100, '0, 4'b1110, 1, 0});
      vecs.push_back('{"p1_step6",  0, 0, 0, '0, 0, 4'b1000, '0, 4'b1100, 1, 1});
      vecs.push_back('{"p1_done",   0, 0, 0, '0, 0, 4'b0000, '0, 4'b1000, 0, 0});
      vecs.push_back('{"p1_idle",   0, 0, 0, '0, 0, 4'b0000, '0, 4'b0000, 0, 0});

      // Pass 2: in_valid toggles every cycle.
      // Abort lands on drain step 3.
      vecs.push_back('{"p2_start",  1, 0, 0, '0, 1, 4'b0000, '0, 4'b0000, 1, 0});
      vecs.push_back('{"p2_beatA",  0, 0, 1, A,  1, 4'b1111, A,  4'b0000, 1, 0});
      vecs.push_back('{"p2_gap1",   0, 0, 0, J,  1, 4'b0000, '0, 4'b0000, 1, 0});
      vecs.push_back('{"p2_beatB",  0, 0, 1, B,  1, 4'b1111, B,  4'b0000, 1, 0});
      vecs.push_back('{"p2_gap2",   0, 0, 0, J,  1, 4'b0000, '0, 4'b0000, 1, 0});
      vecs.push_back('{"p2_beatC",  0, 0, 1, C,  1, 4'b1111, C,  4'b0000, 1, 0});
      vecs.push_back('{"p2_gap3",   0, 0, 0, J,  1, 4'b0000, '0, 4'b0000, 1, 0});
      vecs.push_back('{"p2_beatD",  0, 0, 1, D,  0, 4'b1111, D,  4'b0000, 1, 0});
      vecs.push_back('{"p2_step0",  0, 0, 0, '0, 0, 4'b0001, '0, 4'b0000, 1, 0});
      vecs.push_back('{"p2_step1",  0, 0, 0, '0, 0, 4'b0011, '0, 4'b0001, 1, 0});
      vecs.push_back('{"p2_step2",  0, 0, 0, '0, 0, 4'b0111, '0, 4'b0011, 1, 0});
      vecs.push_back('{"p2_abort",  0, 1, 0, '0, 0, 4'b0000, '0, 4'b0000, 0, 0});
      vecs.push_back('{"p2_idle",   0, 0, 0, '0, 0, 4'b0000, '0, 4'b0000, 0, 0});

      // Pass 3: an abort in the same cycle as an offered beat.
      // The abort wins, and the beat is neither taken nor forwarded.
      vecs.push_back('{"p3_start",  1, 0, 0, '0, 1, 4'b0000, '0, 4'b0000, 1, 0});
      vecs.push_back('{"p3_abtbeat",0, 1, 1, A,  0, 4'b0000, '0, 4'b0000, 0, 0});

      start    = 1'b0;
      abort    = 1'b0;
      inValid  = 1'b0;
      inData   = '0;
      start1   = 1'b0;
      abort1   = 1'b0;
      inValid1 = 1'b0;
      inData1  = '0;

      rst_n = 1'b0;
      #12;
      checkOutput("reset_state", 0, '0, '0, '0, 0, 0);
      checkOutput1("reset_state_dim1", 0, 0, 8'h00, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Apply the vector table.
      foreach (vecs[k]) begin
         applyStimulus(vecs[k].start, vecs[k].abort, vecs[k].inValid, vecs[k].inData);
         checkOutput(vecs[k].name, vecs[k].expReady, vecs[k].expEn, vecs[k].expD,
                     vecs[k].expOv, vecs[k].expBusy, vecs[k].expDone);
      end

      // Asynchronous reset pulse in the middle of FILL, after two beats.
      applyStimulus(1, 0, 0, '0);
      applyStimulus(0, 0, 1, A);
      applyStimulus(0, 0, 1, B);
      checkOutput("rst_pre", 1, 4'b1111, B, 4'b0000, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_async", 0, '0, '0, '0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // After release a new start needs four fresh beats.
      applyStimulus(1, 0, 0, '0);
      checkOutput("rst_restart", 1, 4'b0000, '0, 4'b0000, 1, 0);
      applyStimulus(0, 0, 1, C);
      applyStimulus(0, 0, 1, D);
      applyStimulus(0, 0, 1, A);
      checkOutput("rst_beat3", 1, 4'b1111, A, 4'b0000, 1, 0);
      applyStimulus(0, 0, 1, B);
      checkOutput("rst_beat4", 0, 4'b1111, B, 4'b0000, 1, 0);
      applyStimulus(0, 0, 0, '0);
      checkOutput("rst_step0", 0, 4'b0001, '0, 4'b0000, 1, 0);
      applyStimulus(0, 1, 0, '0);
      checkOutput("rst_cleanup", 0, 4'b0000, '0, 4'b0000, 0, 0);

      // start and in_valid held high for a whole pass.
      // DONE follows 12 edges after the start.
      // The next FILL begins one IDLE cycle later.
      for (int k = 1; k <= 14; k++) begin
         applyStimulus(1, 0, 1, C);
         if (k == 12) checkOutput("held_done", 0, 4'b1000, '0, 4'b1100, 1, 1);
         if (k == 13) checkOutput("held_idle", 0, 4'b0000, '0, 4'b1000, 0, 0);
         if (k == 14) checkOutput("held_refill", 1, 4'b0000, '0, 4'b0000, 1, 0);
      end
      applyStimulus(0, 1, 0, '0);
      checkOutput("held_cleanup", 0, 4'b0000, '0, 4'b0000, 0, 0);

      // DIM=1: one beat, one drain step, then DONE.
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      #1;
      checkOutput1("d1_start", 1, 0, 8'h00, 0, 1, 0);
      @(negedge clk);
      start1   = 1'b0;
      inValid1 = 1'b1;
      inData1  = 8'hA5;
      @(posedge clk);
      #1;
      checkOutput1("d1_beat", 0, 1, 8'hA5, 0, 1, 0);
      @(negedge clk);
      inValid1 = 1'b0;
      inData1  = 8'h00;
      @(posedge clk);
      #1;
      checkOutput1("d1_step0", 0, 1, 8'h00, 0, 1, 1);
      @(posedge clk);
      #1;
      checkOutput1("d1_idle", 0, 0, 8'h00, 1, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
